// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//
// Control FSM for the multicycle core. Each instruction walks through
// FETCH -> DECODE -> EXECUTE -> (MEM) -> WRITEBACK, and the FSM raises the
// memory requests and the IR / register-file / PC write strobes along the way.
// A 64-bit counter tracks retired instructions (one per PC write). The core
// parks in HALT on a trap or when a memory access waits too long.
//
// Parameters
//   TIMEOUT              max cycles to wait for a ready in one access (0 = never)
// Ports
//   clock, reset         clock (rising edge) and async active-high reset
//   inst_ready           instruction memory returns data this cycle
//   data_ready           data memory completes the access this cycle
//   inst_is_load/store/trap  decode class of the IR, sampled in EXECUTE
//   inst_read_enable     instruction memory request
//   ir_write_enable      latch fetched word into the IR
//   data_read_enable     data memory read request
//   data_write_enable    data memory write request
//   regfile_write_enable register-file write strobe
//   pc_write_enable      program-counter write strobe
//   halted, halt_cause   HALT indication and reason (1 = trap, 2 = timeout)
//   retired_count        instructions retired so far (wraps at 2**64)
//   state                debug view of the FSM encoding
module multicycle_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inst_ready,
  input  logic        data_ready,
  input  logic        inst_is_load,
  input  logic        inst_is_store,
  input  logic        inst_is_trap,
  output logic        inst_read_enable,
  output logic        ir_write_enable,
  output logic        data_read_enable,
  output logic        data_write_enable,
  output logic        regfile_write_enable,
  output logic        pc_write_enable,
  output logic        halted,
  output logic [1:0]  halt_cause,
  output logic [63:0] retired_count,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [1:0] CAUSE_TRAP    = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  // Wide enough to hold TIMEOUT-1, the last cycle a wait may last.
  localparam int              WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_count_q, wait_count_d;
  logic                is_store_q, is_store_d;
  logic [1:0]          halt_cause_q, halt_cause_d;
  logic [63:0]         retired_count_q, retired_count_d;

  logic                wait_expired;
  logic [WAIT_W-1:0]   wait_count_inc;

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of the others; reset is asynchronous, so strobes (decoded
  // from state) drop the moment reset rises.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= S_FETCH;
      wait_count_q    <= '0;
      is_store_q      <= 1'b0;
      halt_cause_q    <= 2'd0;
      retired_count_q <= 64'd0;
    end else begin
      state_q         <= state_d;
      wait_count_q    <= wait_count_d;
      is_store_q      <= is_store_d;
      halt_cause_q    <= halt_cause_d;
      retired_count_q <= retired_count_d;
    end
  end

  // The wait counter saturates instead of wrapping, so a disabled timeout can
  // never alias back to a small count.
  always_comb begin
    wait_expired   = (TIMEOUT != 0) && (wait_count_q == WAIT_LAST);
    wait_count_inc = (wait_count_q == WAIT_MAX) ? wait_count_q
                                                : wait_count_q + WAIT_W'(1);
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d              = state_q;
    wait_count_d         = wait_count_q;
    is_store_d           = is_store_q;
    halt_cause_d         = halt_cause_q;
    inst_read_enable     = 1'b0;
    ir_write_enable      = 1'b0;
    data_read_enable     = 1'b0;
    data_write_enable    = 1'b0;
    regfile_write_enable = 1'b0;
    pc_write_enable      = 1'b0;
    halted               = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        inst_read_enable = 1'b1;
        // A ready arriving on the last allowed cycle beats the timeout.
        if (inst_ready) begin
          ir_write_enable = 1'b1;
          state_d         = S_DECODE;
        end else if (wait_expired) begin
          state_d      = S_HALT;
          halt_cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_count_d = wait_count_inc;
        end
      end

      S_DECODE: state_d = S_EXECUTE;

      S_EXECUTE: begin
        // Load and store together is an impossible decode; treat it as a trap.
        if (inst_is_trap || (inst_is_load && inst_is_store)) begin
          state_d      = S_HALT;
          halt_cause_d = CAUSE_TRAP;
        end else if (inst_is_load || inst_is_store) begin
          state_d      = S_MEM;
          is_store_d   = inst_is_store;
          wait_count_d = '0;
        end else begin
          state_d = S_WRITEBACK;
        end
      end

      S_MEM: begin
        data_read_enable  = !is_store_q;
        data_write_enable = is_store_q;
        if (data_ready) begin
          // A store has nothing to write back, so it retires right here.
          if (is_store_q) begin
            pc_write_enable = 1'b1;
            state_d         = S_FETCH;
            wait_count_d    = '0;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (wait_expired) begin
          state_d      = S_HALT;
          halt_cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_count_d = wait_count_inc;
        end
      end

      S_WRITEBACK: begin
        regfile_write_enable = 1'b1;
        pc_write_enable      = 1'b1;
        state_d              = S_FETCH;
        wait_count_d         = '0;
      end

      S_HALT: halted = 1'b1;

      default: state_d = S_FETCH;
    endcase

    retired_count_d = retired_count_q + 64'(pc_write_enable);
  end

  assign halt_cause    = halt_cause_q;
  assign retired_count = retired_count_q;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer.
//
// Stimulus is planned per instruction (class, fetch wait, memory wait). The
// plan expands each instruction into the cycle-by-cycle inputs to drive and
// the outputs the sequencer must show, from the instruction-level rules.
// A driver replays the plan; one compare process checks every planned cycle
// and logs when the main strobes fired, so fixed scenarios can be pinned
// against hand-computed cycle numbers.
module tb_multicycle_sequencer;

  localparam int TIMEOUT = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        inst_ready = 1'b0, data_ready = 1'b0;
  logic        inst_is_load = 1'b0, inst_is_store = 1'b0, inst_is_trap = 1'b0;
  logic        inst_read_enable, ir_write_enable, data_read_enable;
  logic        data_write_enable, regfile_write_enable, pc_write_enable, halted;
  logic [1:0]  halt_cause;
  logic [63:0] retired_count;
  logic [2:0]  state;

  always #5 clock = ~clock;

  multicycle_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clock                (clock),
    .reset                (reset),
    .inst_ready           (inst_ready),
    .data_ready           (data_ready),
    .inst_is_load         (inst_is_load),
    .inst_is_store        (inst_is_store),
    .inst_is_trap         (inst_is_trap),
    .inst_read_enable     (inst_read_enable),
    .ir_write_enable      (ir_write_enable),
    .data_read_enable     (data_read_enable),
    .data_write_enable    (data_write_enable),
    .regfile_write_enable (regfile_write_enable),
    .pc_write_enable      (pc_write_enable),
    .halted               (halted),
    .halt_cause           (halt_cause),
    .retired_count        (retired_count),
    .state                (state)
  );

  typedef enum int {K_ALU, K_LOAD, K_STORE, K_TRAP, K_FTO, K_MTO} kind_t;
  typedef struct packed { logic ir, dr, ld, st, tr; } in_t;
  typedef struct packed {
    logic inst_re, ir_we, dre, dwe, rf_we, pc_we, halted;
    logic [1:0]  cause;
    logic [2:0]  st;
    logic [63:0] ret;
  } out_t;

  // Strobe groups: {inst_re, ir_we, dre, dwe, rf_we, pc_we, halted}
  localparam logic [6:0] SB_FETCH = 7'b1000000;
  localparam logic [6:0] SB_IRW   = 7'b1100000;
  localparam logic [6:0] SB_NONE  = 7'b0000000;
  localparam logic [6:0] SB_RD    = 7'b0010000;
  localparam logic [6:0] SB_WR    = 7'b0001000;
  localparam logic [6:0] SB_WRPC  = 7'b0001010;
  localparam logic [6:0] SB_WB    = 7'b0000110;
  localparam logic [6:0] SB_HALT  = 7'b0000001;

  in_t         in_q[$];
  out_t        exp_q[$];
  logic [63:0] model_ret = 64'd0;

  int   tests = 0;
  int   fails = 0;
  out_t exp_cur;
  logic exp_valid = 1'b0;
  int   cyc = 0;
  int   pc_log[$], rf_log[$], dre_log[$], dwe_log[$], halt_log[$];

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic check_log(input string name, input int got[$], input int expv[$]);
    check({name, "_len"}, got.size(), expv.size());
    for (int k = 0; k < expv.size() && k < got.size(); k++)
      check($sformatf("%s[%0d]", name, k), got[k], expv[k]);
  endtask

  function automatic in_t noise();
    return in_t'($urandom_range(0, 31));
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One planned cycle: inputs to drive and outputs required. The retired
  // count seen in a cycle is the number of PC writes planned before it.
  task automatic add(input logic [2:0] stv, input in_t i, input logic [6:0] sb,
                     input logic [1:0] cause);
    out_t o;
    o = {sb, cause, stv, model_ret};
    in_q.push_back(i);
    exp_q.push_back(o);
    if (sb[1]) model_ret = model_ret + 64'd1;
  endtask

  task automatic plan_halt(input logic [1:0] cause, input int n);
    for (int c = 0; c < n; c++) add(3'd5, noise(), SB_HALT, cause);
  endtask

  // f = cycles inst_ready stays low, m = cycles data_ready stays low.
  task automatic plan_inst(input kind_t k, input logic mto_store, input int f,
                           input int m, input int halt_n);
    in_t  i;
    logic is_st;
    for (int c = 0; c < f; c++) begin
      i = noise(); i.ir = 1'b0; add(3'd0, i, SB_FETCH, 2'd0);
    end
    if (k == K_FTO) begin plan_halt(2'd2, halt_n); return; end
    i = noise(); i.ir = 1'b1; add(3'd0, i, SB_IRW, 2'd0);
    add(3'd1, noise(), SB_NONE, 2'd0);
    is_st = (k == K_STORE) || (k == K_MTO && mto_store);
    i = noise();
    case (k)
      K_ALU:   {i.ld, i.st, i.tr} = 3'b000;
      K_LOAD:  {i.ld, i.st, i.tr} = 3'b100;
      K_STORE: {i.ld, i.st, i.tr} = 3'b010;
      K_TRAP:  if (rbit()) i.tr = 1'b1; else {i.ld, i.st, i.tr} = 3'b110;
      default: {i.ld, i.st, i.tr} = {!is_st, is_st, 1'b0};
    endcase
    add(3'd2, i, SB_NONE, 2'd0);
    if (k == K_TRAP) begin plan_halt(2'd1, halt_n); return; end
    if (k == K_ALU) begin add(3'd4, noise(), SB_WB, 2'd0); return; end
    for (int c = 0; c < m; c++) begin
      i = noise(); i.dr = 1'b0; add(3'd3, i, is_st ? SB_WR : SB_RD, 2'd0);
    end
    if (k == K_MTO) begin plan_halt(2'd2, halt_n); return; end
    i = noise(); i.dr = 1'b1; add(3'd3, i, is_st ? SB_WRPC : SB_RD, 2'd0);
    if (!is_st) add(3'd4, noise(), SB_WB, 2'd0);
  endtask

  // Replays the plan; returns right after driving the last planned cycle.
  task automatic run_plan();
    pc_log.delete(); rf_log.delete(); dre_log.delete();
    dwe_log.delete(); halt_log.delete();
    for (int c = 0; c < in_q.size(); c++) begin
      @(negedge clock);
      {inst_ready, data_ready, inst_is_load, inst_is_store, inst_is_trap} = in_q[c];
      exp_cur   = exp_q[c];
      cyc       = c + 1;
      exp_valid = 1'b1;
    end
    in_q.delete();
    exp_q.delete();
  endtask

  // Release lands just after a rising edge so the first planned cycle is
  // the first FETCH cycle the sequencer counts.
  task automatic do_reset();
    @(negedge clock);
    exp_valid = 1'b0;
    {inst_ready, data_ready, inst_is_load, inst_is_store, inst_is_trap} = '0;
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    model_ret = 64'd0;
    #1 check("reset_state",
             {inst_read_enable, ir_write_enable, data_read_enable, data_write_enable,
              regfile_write_enable, pc_write_enable, halted, halt_cause, state,
              retired_count},
             {SB_FETCH, 2'd0, 3'd0, 64'd0});
  endtask

  // Single compare process: every planned cycle, mid-way through the low
  // phase of the clock.
  out_t act;
  always @(negedge clock) begin
    #2;
    if (exp_valid) begin
      act = {inst_read_enable, ir_write_enable, data_read_enable, data_write_enable,
             regfile_write_enable, pc_write_enable, halted, halt_cause, state,
             retired_count};
      check($sformatf("cycle%0d", cyc), act, exp_cur);
      if (act.pc_we)  pc_log.push_back(cyc);
      if (act.rf_we)  rf_log.push_back(cyc);
      if (act.dre)    dre_log.push_back(cyc);
      if (act.dwe)    dwe_log.push_back(cyc);
      if (act.halted) halt_log.push_back(cyc);
    end
  end

  initial begin
    int e[$];
    int n, term;
    kind_t k;

    // 3 ALU ops, a load with 3 wait cycles, a zero-wait store, then a trap.
    do_reset();
    for (int j = 0; j < 3; j++) plan_inst(K_ALU, 1'b0, 0, 0, 0);
    plan_inst(K_LOAD, 1'b0, 0, 3, 0);
    plan_inst(K_STORE, 1'b0, 0, 0, 0);
    plan_inst(K_TRAP, 1'b0, 0, 0, 100);
    run_plan();
    #3;
    e = '{4, 8, 12, 20, 24};  check_log("pc_pulses", pc_log, e);
    e = '{4, 8, 12, 20};      check_log("rf_pulses", rf_log, e);
    e = '{16, 17, 18, 19};    check_log("load_read_cycles", dre_log, e);
    e = '{24};                check_log("store_write_cycles", dwe_log, e);
    check("trap_first_halt_cycle", halt_log.size() > 0 ? halt_log[0] : -1, 28);
    check("trap_halt_cycles", halt_log.size(), 100);
    check("trap_retired", retired_count, 64'd5);
    check("trap_cause", {halted, halt_cause}, 3'b101);

    // Fetch timeout: inst_ready never comes.
    do_reset();
    plan_inst(K_FTO, 1'b0, TIMEOUT, 0, 10);
    run_plan();
    #3;
    check("fetch_timeout_first_halt", halt_log.size() > 0 ? halt_log[0] : -1, 5);
    check("fetch_timeout_cause", {halted, halt_cause}, 3'b110);

    // Ready arriving on the last allowed fetch cycle wins.
    do_reset();
    plan_inst(K_ALU, 1'b0, TIMEOUT - 1, 0, 0);
    run_plan();
    #3;
    e = '{7}; check_log("late_ready_pc", pc_log, e);
    check("late_ready_no_halt", halt_log.size(), 0);

    // Asynchronous reset in the middle of a load's MEM wait.
    do_reset();
    plan_inst(K_ALU, 1'b0, 0, 0, 0);
    plan_inst(K_LOAD, 1'b0, 0, 3, 0);
    while (in_q.size() > 9) begin
      void'(in_q.pop_back());
      void'(exp_q.pop_back());
    end
    run_plan();
    #3 reset = 1'b1;
    exp_valid = 1'b0;
    #1;
    check("async_reset_strobes",
          {inst_read_enable, ir_write_enable, data_read_enable, data_write_enable,
           regfile_write_enable, pc_write_enable, halted}, SB_FETCH);
    check("async_reset_state", state, 3'd0);
    check("async_reset_retired", retired_count, 64'd0);

    // Random instruction streams, each closed by a random terminator.
    for (int b = 0; b < 12; b++) begin
      do_reset();
      n = $urandom_range(3, 15);
      for (int j = 0; j < n; j++) begin
        k = kind_t'($urandom_range(0, 2));
        plan_inst(k, 1'b0, $urandom_range(0, TIMEOUT - 1),
                  $urandom_range(0, TIMEOUT - 1), 0);
      end
      term = $urandom_range(0, 3);
      case (term)
        0: plan_inst(K_TRAP, 1'b0, $urandom_range(0, TIMEOUT - 1), 0,
                     $urandom_range(3, 12));
        1: plan_inst(K_FTO, 1'b0, TIMEOUT, 0, $urandom_range(3, 12));
        2: plan_inst(K_MTO, rbit(), $urandom_range(0, TIMEOUT - 1), TIMEOUT,
                     $urandom_range(3, 12));
        default: ;
      endcase
      run_plan();
    end

    @(negedge clock);
    exp_valid = 1'b0;
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
